// File: rtl/avalon_reg_bank_if.sv
// ---------------------------------------------------------------------------
// avalon_reg_bank_if
// Avalon-MM style slave bus used by avalon_reg_bank.
//   address       : {reg_index, mode[1:0]}
//   chip_select   : slave select
//   read / write  : transfer strobes (asserting both is a no-op)
//   byte_enable   : per-byte write lane enables
//   writedata     : write data / bit mask
//   readdata      : registered read data
//   readdatavalid : one-cycle pulse qualifying readdata
// Modports: master drives the request side, slave drives the response side.
// ---------------------------------------------------------------------------
interface avalon_reg_bank_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              chip_select;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byte_enable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, chip_select, read, write, byte_enable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chip_select, read, write, byte_enable, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_reg_bank.sv
// ---------------------------------------------------------------------------
// avalon_reg_bank
// Bank of NUM_REGS DATA_W-bit registers behind an Avalon-MM style slave.
// Writes use address[1:0] as an operation: load / set / clear / toggle,
// applied only on enabled byte lanes. Reads have a fixed latency of one
// cycle and never stall. Indices at or above NUM_REGS ignore writes and
// read back as zero.
//
// Ports:
//   clock     : rising-edge clock
//   resetn    : synchronous active-low reset
//   bus       : avalon_reg_bank_if slave modport (address, chip_select,
//               read, write, byte_enable, writedata, readdata,
//               readdatavalid)
//   reg_out   : all registers, register i at [i*DATA_W +: DATA_W]
//   to_lights : register 0
//
// Optional feature macro: REGBANK_WRCNT_EN
//   Adds a DATA_W-bit counter of effective writes (in-range index, non-zero
//   byte_enable). A read with address[1:0]=3 then returns the counter.
// ---------------------------------------------------------------------------
module avalon_reg_bank #(
    parameter int unsigned       NUM_REGS  = 4,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       resetn,
    avalon_reg_bank_if.slave           bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [DATA_W-1:0]          to_lights
);
    localparam int unsigned IDX_W  = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS);
    localparam int unsigned ADDR_W = IDX_W + 2;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam logic [IDX_W:0] NUM_REGS_L = NUM_REGS[IDX_W:0];

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'd0,
        MODE_SET    = 2'd1,
        MODE_CLEAR  = 2'd2,
        MODE_TOGGLE = 2'd3
    } wr_mode_t;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]  idx;
    wr_mode_t          mode;
    logic              wr_acc;
    logic              rd_acc;
    logic              idx_ok;
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] op_val;
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] rd_val;

    always_comb begin
        idx    = bus.address[ADDR_W-1:2];
        mode   = wr_mode_t'(bus.address[1:0]);
        wr_acc = bus.chip_select & bus.write & ~bus.read;
        rd_acc = bus.chip_select & bus.read  & ~bus.write;
        idx_ok = ({1'b0, idx} < NUM_REGS_L);
    end

    // Out-of-range indices read as zero; the guard also keeps the array
    // access in bounds when NUM_REGS is not a power of two.
    always_comb begin
        cur_val = '0;
        if (idx_ok) begin
            cur_val = regs[idx];
        end
    end

    always_comb begin
        op_val = bus.writedata;
        unique case (mode)
            MODE_LOAD:   op_val = bus.writedata;
            MODE_SET:    op_val = cur_val | bus.writedata;
            MODE_CLEAR:  op_val = cur_val & ~bus.writedata;
            MODE_TOGGLE: op_val = cur_val ^ bus.writedata;
            default:     op_val = bus.writedata;
        endcase
    end

    // Merge the operation result lane by lane; disabled lanes keep their value.
    always_comb begin
        wr_val = cur_val;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (bus.byte_enable[b]) begin
                wr_val[b*8 +: 8] = op_val[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_acc && idx_ok) begin
            regs[idx] <= wr_val;
        end
    end

`ifdef REGBANK_WRCNT_EN
    logic [DATA_W-1:0] wr_cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_cnt <= '0;
        end else if (wr_acc && idx_ok && (|bus.byte_enable)) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    // Mode 3 on a read selects the counter regardless of reg_index.
    always_comb begin
        rd_val = cur_val;
        if (mode == MODE_TOGGLE) begin
            rd_val = wr_cnt;
        end
    end
`else
    always_comb begin
        rd_val = cur_val;
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= rd_acc;
            if (rd_acc) begin
                bus.readdata <= rd_val;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs[i];
        end
        to_lights = regs[0];
    end
endmodule

// File: tb/tb_avalon_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_avalon_reg_bank
// Directed bench for avalon_reg_bank. Two instances share identical bus
// traffic: dut4 (NUM_REGS=4, RESET_VAL=0xA5) and dut3 (NUM_REGS=3,
// RESET_VAL=0x11), so the non-power-of-two index range is exercised too.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_avalon_reg_bank;
    logic clock;
    logic resetn;

    logic [3:0]  address;
    logic        chip_select;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wd;

    int n_cmp = 0;
    int n_err = 0;

    avalon_reg_bank_if #(.ADDR_W(4), .DATA_W(32)) bus4 ();
    avalon_reg_bank_if #(.ADDR_W(4), .DATA_W(32)) bus3 ();

    assign bus4.address     = address;
    assign bus4.chip_select = chip_select;
    assign bus4.read        = rd;
    assign bus4.write       = wr;
    assign bus4.byte_enable = be;
    assign bus4.writedata   = wd;
    assign bus3.address     = address;
    assign bus3.chip_select = chip_select;
    assign bus3.read        = rd;
    assign bus3.write       = wr;
    assign bus3.byte_enable = be;
    assign bus3.writedata   = wd;

    logic [127:0] reg_out4;
    logic [31:0]  lights4;
    logic [95:0]  reg_out3;
    logic [31:0]  lights3;

    avalon_reg_bank #(
        .NUM_REGS (4),
        .DATA_W   (32),
        .RESET_VAL(32'h0000_00A5)
    ) dut4 (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus4),
        .reg_out  (reg_out4),
        .to_lights(lights4)
    );

    avalon_reg_bank #(
        .NUM_REGS (3),
        .DATA_W   (32),
        .RESET_VAL(32'h0000_0011)
    ) dut3 (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus3),
        .reg_out  (reg_out3),
        .to_lights(lights3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        chip_select = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        be          = 4'h0;
        wd          = 32'h0;
        address     = 4'h0;
    endtask

    task automatic wr_req(input logic [1:0] idx, input logic [1:0] mode,
                          input logic [3:0] b, input logic [31:0] d);
        address     = {idx, mode};
        chip_select = 1'b1;
        wr          = 1'b1;
        rd          = 1'b0;
        be          = b;
        wd          = d;
    endtask

    task automatic rd_req(input logic [1:0] idx, input logic [1:0] mode);
        address     = {idx, mode};
        chip_select = 1'b1;
        rd          = 1'b1;
        wr          = 1'b0;
        be          = 4'h0;
        wd          = 32'h0;
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [1:0] mode,
                            input logic [3:0] b, input logic [31:0] d);
        wr_req(idx, mode, b, d);
        tick();
        set_idle();
    endtask

    task automatic do_read(input logic [1:0] idx, input logic [1:0] mode);
        rd_req(idx, mode);
        tick();
        set_idle();
    endtask

    initial begin
        resetn = 1'b0;
        set_idle();
        tick();
        tick();

        // Reset state
        check32("rst_rd4", bus4.readdata, 32'h0);
        check1 ("rst_rdv4", bus4.readdatavalid, 1'b0);
        check1 ("rst_rdv3", bus3.readdatavalid, 1'b0);
        for (int i = 0; i < 4; i++) check32("rst_reg4", reg_out4[i*32 +: 32], 32'h0000_00A5);
        for (int i = 0; i < 3; i++) check32("rst_reg3", reg_out3[i*32 +: 32], 32'h0000_0011);
        check32("rst_lights4", lights4, 32'h0000_00A5);
        check32("rst_lights3", lights3, 32'h0000_0011);
        resetn = 1'b1;

        // Read of reset value, one-cycle pulse, readdata holds afterwards
        do_read(2'd2, 2'd0);
        check1 ("rd2_rdv4", bus4.readdatavalid, 1'b1);
        check32("rd2_rd4", bus4.readdata, 32'h0000_00A5);
        check1 ("rd2_rdv3", bus3.readdatavalid, 1'b1);
        check32("rd2_rd3", bus3.readdata, 32'h0000_0011);
        tick();
        check1 ("rd2_pulse_end", bus4.readdatavalid, 1'b0);
        check32("rd2_hold", bus4.readdata, 32'h0000_00A5);

        // Byte-lane modes on reg1
        do_write(2'd1, 2'd0, 4'b1111, 32'h0000_0000);
        check32("r1_zero", reg_out4[63:32], 32'h0000_0000);
        do_write(2'd1, 2'd0, 4'b1100, 32'hFFFF_0000);
        check32("r1_load", reg_out4[63:32], 32'hFFFF_0000);
        do_write(2'd1, 2'd1, 4'b0001, 32'h0000_00F0);
        check32("r1_set", reg_out4[63:32], 32'hFFFF_00F0);
        do_write(2'd1, 2'd2, 4'b1111, 32'h00F0_0000);
        check32("r1_clear", reg_out4[63:32], 32'hFF0F_00F0);
        do_write(2'd1, 2'd3, 4'b1001, 32'h8000_0001);
        check32("r1_toggle4", reg_out4[63:32], 32'h7F0F_00F1);
        check32("r1_toggle3", reg_out3[63:32], 32'h7F0F_00F1);
        check32("r0_untouched", reg_out4[31:0], 32'h0000_00A5);

        // Mode bits ignored on a non-counter read
        do_read(2'd1, 2'd2);
        check32("rd1_mode2", bus4.readdata, 32'h7F0F_00F1);

        // to_lights follows reg0; read+write together does nothing
        do_write(2'd0, 2'd0, 4'b1111, 32'h1234_5678);
        check32("lights_load4", lights4, 32'h1234_5678);
        check32("lights_load3", lights3, 32'h1234_5678);
        wr_req(2'd0, 2'd0, 4'b1111, 32'h0);
        rd = 1'b1;
        tick();
        set_idle();
        check32("rw_lights", lights4, 32'h1234_5678);
        check1 ("rw_rdv", bus4.readdatavalid, 1'b0);
        tick();
        check1 ("rw_rdv_next", bus4.readdatavalid, 1'b0);

        // byte_enable=0 and chip_select=0 writes are no-ops
        do_write(2'd0, 2'd0, 4'b0000, 32'h0);
        check32("be0_lights", lights4, 32'h1234_5678);
        wr_req(2'd0, 2'd0, 4'b1111, 32'h0);
        chip_select = 1'b0;
        tick();
        set_idle();
        check32("cs0_lights", lights4, 32'h1234_5678);

        // Back-to-back reads
        rd_req(2'd0, 2'd0);
        tick();
        check1 ("b2b_rdv_a", bus4.readdatavalid, 1'b1);
        check32("b2b_rd_a", bus4.readdata, 32'h1234_5678);
        rd_req(2'd1, 2'd0);
        tick();
        check1 ("b2b_rdv_b", bus4.readdatavalid, 1'b1);
        check32("b2b_rd_b", bus4.readdata, 32'h7F0F_00F1);
        set_idle();
        tick();
        check1 ("b2b_rdv_end", bus4.readdatavalid, 1'b0);
        check32("b2b_hold", bus4.readdata, 32'h7F0F_00F1);

        // Index 3: out of range for dut3, valid for dut4
        do_write(2'd3, 2'd0, 4'b1111, 32'hDEAD_BEEF);
        check32("idx3_reg4", reg_out4[127:96], 32'hDEAD_BEEF);
        check32("idx3_r0_3", reg_out3[31:0],  32'h1234_5678);
        check32("idx3_r1_3", reg_out3[63:32], 32'h7F0F_00F1);
        check32("idx3_r2_3", reg_out3[95:64], 32'h0000_0011);
        do_read(2'd3, 2'd0);
        check1 ("idx3_rdv3", bus3.readdatavalid, 1'b1);
        check32("idx3_rd3", bus3.readdata, 32'h0);
        check32("idx3_rd4", bus4.readdata, 32'hDEAD_BEEF);

        // Read and write presented during reset are discarded
        rd_req(2'd1, 2'd0);
        resetn = 1'b0;
        tick();
        check1 ("mrst_rdv", bus4.readdatavalid, 1'b0);
        check32("mrst_rd", bus4.readdata, 32'h0);
        check32("mrst_reg3_4", reg_out4[127:96], 32'h0000_00A5);
        check32("mrst_reg1_3", reg_out3[63:32], 32'h0000_0011);
        wr_req(2'd0, 2'd0, 4'b1111, 32'hFFFF_FFFF);
        tick();
        resetn = 1'b1;
        set_idle();
        check32("mrst_lights", lights4, 32'h0000_00A5);
        check1 ("mrst_rdv2", bus4.readdatavalid, 1'b0);
        tick();
        check1 ("mrst_rdv3", bus4.readdatavalid, 1'b0);
        check32("mrst_lights2", lights4, 32'h0000_00A5);

        // Write counter / mode-3 read
        do_write(2'd0, 2'd0, 4'b1111, 32'h0000_0001);
        do_write(2'd1, 2'd0, 4'b1111, 32'h0000_0002);
        do_write(2'd2, 2'd0, 4'b1111, 32'h0000_0003);
        do_write(2'd0, 2'd0, 4'b0000, 32'hFFFF_FFFF);
        do_write(2'd3, 2'd0, 4'b1111, 32'h0000_0004);
        check32("cnt_r0_3", reg_out3[31:0], 32'h0000_0001);
        check32("cnt_r3_4", reg_out4[127:96], 32'h0000_0004);
        do_read(2'd0, 2'd3);
`ifdef REGBANK_WRCNT_EN
        check32("m3_idx0_rd3", bus3.readdata, 32'd3);
        check32("m3_idx0_rd4", bus4.readdata, 32'd4);
`else
        check32("m3_idx0_rd3", bus3.readdata, 32'h0000_0001);
        check32("m3_idx0_rd4", bus4.readdata, 32'h0000_0001);
`endif
        check1("m3_rdv", bus3.readdatavalid, 1'b1);
        do_read(2'd3, 2'd3);
`ifdef REGBANK_WRCNT_EN
        check32("m3_idx3_rd3", bus3.readdata, 32'd3);
        check32("m3_idx3_rd4", bus4.readdata, 32'd4);
`else
        check32("m3_idx3_rd3", bus3.readdata, 32'h0);
        check32("m3_idx3_rd4", bus4.readdata, 32'h0000_0004);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/avalon_reg_bank.md
AVALON_REG_BANK -- requirements
Module: avalon_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 4, number of DATA_W-bit registers (1..64).
REQ-002 Parameter DATA_W, default 32, register/bus width; SHALL be a multiple of 8.
REQ-003 Parameter RESET_VAL, default 0, DATA_W-bit value loaded into every register at reset.
REQ-004 Derived IDX_W = max(1, ceil(log2(NUM_REGS))); ADDR_W = IDX_W+2; BE_W = DATA_W/8.
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 address  input  ADDR_W  {reg_index[IDX_W-1:0], mode[1:0]}.
REQ-008 chip_select  input  1  slave select.
REQ-009 read  input  1  read strobe.
REQ-010 write  input  1  write strobe.
REQ-011 byte_enable  input  BE_W  per-byte write lane enables.
REQ-012 writedata  input  DATA_W  write data / bit mask.
REQ-013 readdata  output  DATA_W  registered read data.
REQ-014 readdatavalid  output  1  one-cycle pulse qualifying readdata.
REQ-015 reg_out  output  NUM_REGS*DATA_W  all registers, register i at bits [i*DATA_W +: DATA_W].
REQ-016 to_lights  output  DATA_W  register 0 contents (equal to reg_out[DATA_W-1:0]).

Function
REQ-017 Accepted write = chip_select & write & ~read; accepted read = chip_select & read & ~write; read&write together SHALL do nothing and produce no readdatavalid.
REQ-018 Write modes by address[1:0], per enabled byte lane only: 0 load (r=wd), 1 set (r|=wd), 2 clear (r&=~wd), 3 toggle (r^=wd).
REQ-019 Disabled byte lanes SHALL be unchanged; byte_enable=0 SHALL be a no-op write.
REQ-020 Write effect SHALL be visible on reg_out/to_lights on the cycle after the accepting edge.
REQ-021 Read latency 1: readdata updated and readdatavalid=1 on the edge after acceptance; readdatavalid=0 on all other cycles.
REQ-022 Read returns register value as it was in the accepting cycle; address[1:0] ignored on reads except per REQ-029.
REQ-023 readdata SHALL hold its last value when no read is accepted.
REQ-024 reg_index >= NUM_REGS: writes ignored; reads return 0 with readdatavalid=1.
REQ-025 Back-to-back reads on consecutive cycles SHALL give back-to-back readdatavalid pulses; no waitrequest, never stalls.

Reset
REQ-026 With resetn=0 at a rising edge: all registers=RESET_VAL, readdata=0, readdatavalid=0, write counter=0.
REQ-027 A read or write presented in a reset cycle SHALL be discarded (no readdatavalid on the following cycle, no register change).

Configuration
REQ-028 Macro REGBANK_WRCNT_EN: when defined, a DATA_W-bit counter increments once per accepted write with reg_index < NUM_REGS and byte_enable != 0, wrapping from all-ones to 0.
REQ-029 With REGBANK_WRCNT_EN defined, a read with address[1:0]=3 returns the counter (reg_index ignored); without it, counter logic SHALL be absent and mode 3 reads return the register per REQ-022.

Verification
REQ-030 Reset, NUM_REGS=4, DATA_W=32, RESET_VAL=0x0000_00A5; read idx 2 -> readdata=0x0000_00A5, readdatavalid high one cycle.
REQ-031 Load 0xFFFF_0000 to idx1 with byte_enable=4'b1100, then set 0x0000_00F0 with 4'b0001, clear 0x00F0_0000 with 4'b1111, toggle 0x8000_0001 with 4'b1001 -> reg1 = 0x7F0F_00F1.
REQ-032 Load 0x1234_5678 to idx0 -> to_lights=0x1234_5678 next cycle; read and write together to idx0 with 0 -> no change, no readdatavalid.
REQ-033 NUM_REGS=3: write idx3 -> no register changes; read idx3 -> readdata=0, readdatavalid=1.
REQ-034 REGBANK_WRCNT_EN defined: 5 accepted writes (one with byte_enable=0, one to idx3 with NUM_REGS=3) -> mode-3 read returns 3; undefined -> mode-3 read of idx0 returns reg0.
REQ-035 Read accepted while resetn=0 mid-sequence -> readdatavalid stays 0; registers return to RESET_VAL.
